// File: rtl/tx_chunk_scheduler.sv
// rtl/tx_chunk_scheduler.sv - round-robin arbiter that frames one pending source's chunk onto the shared UART
module tx_chunk_scheduler #(
    parameter int NUM_SOURCES   = 4,
    parameter int PAYLOAD_BYTES = 1
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic [NUM_SOURCES-1:0]                 src_should_update,
    input  logic [8*NUM_SOURCES-1:0]               src_chunk_type,
    input  logic [8*PAYLOAD_BYTES*NUM_SOURCES-1:0] src_chunk_bytes,
    output logic [NUM_SOURCES-1:0]                 src_ack,
    output logic                                   uart_tx_valid,
    output logic [7:0]                             uart_tx_data,
    input  logic                                   uart_tx_ready,
    output logic                                   busy
);
    localparam int PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int IDX_W = $clog2(PAYLOAD_BYTES) + 1;
    localparam int PAY_W = 8 * PAYLOAD_BYTES;

    typedef enum logic [1:0] {IDLE, SEND_TYPE, SEND_PAYLOAD, ACK} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] src_q, src_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [7:0]       type_q, type_d;
    logic [PAY_W-1:0] payload_q, payload_d;

    logic             req_found;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] cand;
    logic [PTR_W:0]   cand_w;
    logic [7:0]       grant_type;
    logic [PAY_W-1:0] grant_payload;
    logic [PAY_W-1:0] payload_shifted;

    // First pending source at or above rr_ptr, wrapping around.
    always_comb begin : arbiter
        req_found = 1'b0;
        grant_idx = '0;
        cand_w    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            cand_w = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand_w >= (PTR_W+1)'(NUM_SOURCES)) begin
                cand_w = cand_w - (PTR_W+1)'(NUM_SOURCES);
            end
            cand = cand_w[PTR_W-1:0];
            if (!req_found && src_should_update[cand]) begin
                req_found = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin : grant_mux
        grant_type    = '0;
        grant_payload = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                grant_type    = src_chunk_type[8*i +: 8];
                grant_payload = src_chunk_bytes[PAY_W*i +: PAY_W];
            end
        end
    end

    assign payload_shifted = payload_q >> {byte_idx_q, 3'b000};

    always_comb begin : fsm
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        src_d         = src_q;
        byte_idx_d    = byte_idx_q;
        type_d        = type_q;
        payload_d     = payload_q;
        src_ack       = '0;
        uart_tx_valid = 1'b0;
        uart_tx_data  = '0;
        unique case (state_q)
            IDLE: begin
                if (req_found) begin
                    src_d      = grant_idx;
                    type_d     = grant_type;
                    payload_d  = grant_payload;
                    byte_idx_d = '0;
                    state_d    = SEND_TYPE;
                end
            end
            SEND_TYPE: begin
                uart_tx_valid = 1'b1;
                uart_tx_data  = type_q;
                if (uart_tx_ready) begin
                    state_d = SEND_PAYLOAD;
                end
            end
            SEND_PAYLOAD: begin
                uart_tx_valid = 1'b1;
                uart_tx_data  = payload_shifted[7:0];
                if (uart_tx_ready) begin
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == IDX_W'(PAYLOAD_BYTES - 1)) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                src_ack[src_q] = 1'b1;
                rr_ptr_d = (src_q == PTR_W'(NUM_SOURCES - 1)) ? '0 : src_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            src_q      <= '0;
            byte_idx_q <= '0;
            type_q     <= '0;
            payload_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            src_q      <= src_d;
            byte_idx_q <= byte_idx_d;
            type_q     <= type_d;
            payload_q  <= payload_d;
        end
    end
endmodule
